note_judge: RTL

- Consumes the beat/note tick pulses produced by the team's beat timing generator, together with the player's pad press.
- Measures the cycle offset between each note and its press, and grades it PERFECT, GOOD, MISS or STRAY.
- Sits between the timing/chart logic and the score/display logic, and keeps a running combo count.

---
 rtl/ddr_pkg.sv | 29 ++
 rtl/rise_detect.sv | 23 ++
 rtl/note_judge.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared types and default timing windows for the rhythm-game judging path.
// Windows default to the 6.3 MHz simulation clock.
package ddr_pkg;

  typedef enum logic [1:0] {
    MISS    = 2'd0,
    GOOD    = 2'd1,
    PERFECT = 2'd2,
    STRAY   = 2'd3
  } grade_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EARLY = 2'd1,
    LATE  = 2'd2
  } judge_state_e;

  localparam int unsigned SIM_CLK_HZ      = 6_300_000;
  localparam int unsigned DEF_PERFECT_WIN = SIM_CLK_HZ / 20;        // 50 ms
  localparam int unsigned DEF_GOOD_WIN    = (SIM_CLK_HZ * 3) / 20;  // 150 ms
  localparam int unsigned DEF_CW          = 36;
  localparam int unsigned DEF_COMBO_W     = 16;

  // A timed hit is PERFECT inside the tight window, otherwise GOOD.
  function automatic grade_e hit_grade(input logic within_perfect);
    return within_perfect ? PERFECT : GOOD;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a synchronous level; the edge pulse is combinational
// from the current level against its registered copy.
module rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic rise_o
);

  logic r_level_q;

  // Clearing the history on reset makes a level held through release look like a new edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~r_level_q;

endmodule

// File: rtl/note_judge.sv
// Grades each note against the pad press by cycle offset and tracks the combo.
// One-cycle registered latency from the deciding input to grade_valid_o; no backpressure.
module note_judge
  import ddr_pkg::*;
#(
  parameter int unsigned PERFECT_WIN = DEF_PERFECT_WIN,
  parameter int unsigned GOOD_WIN    = DEF_GOOD_WIN,
  parameter int unsigned CW          = DEF_CW,
  parameter int unsigned COMBO_W     = DEF_COMBO_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               note_i,
  input  logic               press_i,
  output logic               grade_valid_o,
  output logic [1:0]         grade_o,
  output logic               early_o,
  output logic [CW-1:0]      offset_o,
  output logic [COMBO_W-1:0] combo_o
);

  localparam logic [CW-1:0] L_PERFECT_WIN = CW'(PERFECT_WIN);
  localparam logic [CW-1:0] L_GOOD_WIN    = CW'(GOOD_WIN);
  localparam logic [CW-1:0] L_ONE         = CW'(1);

  logic w_press_rise;

  rise_detect u_press_rise (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .level_i (press_i),
    .rise_o  (w_press_rise)
  );

  judge_state_e       r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_grade_valid;
  grade_e             r_grade;
  logic               r_early;
  logic [CW-1:0]      r_offset;
  logic [COMBO_W-1:0] r_combo;

  judge_state_e       w_state_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_vld;
  grade_e             w_grade;
  logic               w_early;
  logic [CW-1:0]      w_offset;
  logic               w_timeout;
  logic               w_in_perfect;
  logic [COMBO_W-1:0] w_combo_nxt;

  assign w_timeout    = (r_cnt == L_GOOD_WIN);
  assign w_in_perfect = (r_cnt <= L_PERFECT_WIN);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + L_ONE;
    w_vld       = 1'b0;
    w_grade     = MISS;
    w_early     = 1'b0;
    w_offset    = '0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (note_i && w_press_rise) begin
          w_vld   = 1'b1;
          w_grade = PERFECT;
        end else if (note_i) begin
          w_state_nxt = LATE;
          w_cnt_nxt   = L_ONE;
        end else if (w_press_rise) begin
          w_state_nxt = EARLY;
          w_cnt_nxt   = L_ONE;
        end
      end
      LATE: begin
        if (w_press_rise) begin
          w_vld    = 1'b1;
          w_grade  = hit_grade(w_in_perfect);
          w_offset = r_cnt;
          // A note arriving with the press becomes the next pending note.
          w_state_nxt = note_i ? LATE : IDLE;
          w_cnt_nxt   = note_i ? L_ONE : '0;
        end else if (note_i) begin
          w_vld     = 1'b1;
          w_grade   = MISS;
          w_cnt_nxt = L_ONE;
        end else if (w_timeout) begin
          w_vld       = 1'b1;
          w_grade     = MISS;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      EARLY: begin
        if (note_i) begin
          w_vld    = 1'b1;
          w_grade  = hit_grade(w_in_perfect);
          w_early  = 1'b1;
          w_offset = r_cnt;
          w_state_nxt = w_press_rise ? EARLY : IDLE;
          w_cnt_nxt   = w_press_rise ? L_ONE : '0;
        end else if (w_press_rise) begin
          w_vld     = 1'b1;
          w_grade   = STRAY;
          w_early   = 1'b1;
          w_cnt_nxt = L_ONE;
        end else if (w_timeout) begin
          w_vld       = 1'b1;
          w_grade     = STRAY;
          w_early     = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // STRAY is a press with no note to judge, so it neither breaks nor extends the combo.
  always_comb begin
    w_combo_nxt = r_combo;
    if (w_vld) begin
      unique case (w_grade)
        PERFECT, GOOD: if (!(&r_combo)) w_combo_nxt = r_combo + COMBO_W'(1);
        MISS:          w_combo_nxt = '0;
        default:       w_combo_nxt = r_combo;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_grade_valid <= 1'b0;
      r_grade       <= MISS;
      r_early       <= 1'b0;
      r_offset      <= '0;
      r_combo       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_grade_valid <= w_vld;
      r_combo       <= w_combo_nxt;
      if (w_vld) begin
        r_grade  <= w_grade;
        r_early  <= w_early;
        r_offset <= w_offset;
      end
    end
  end

  assign grade_valid_o = r_grade_valid;
  assign grade_o       = r_grade;
  assign early_o       = r_early;
  assign offset_o      = r_offset;
  assign combo_o       = r_combo;

endmodule
